// File: rtl/rs_issue_scheduler_pkg.sv
// rtl/rs_issue_scheduler_pkg.sv - shared types and constants for the reservation station
//
// Purpose: functional-unit encodings, default field widths and the entry record
// shared by rs_issue_scheduler and its helpers.
package rs_pkg;

    localparam int TAG_W     = 6;
    localparam int ROB_W     = 5;
    localparam int PAYLOAD_W = 32;

    localparam logic FU_ALU = 1'b0;
    localparam logic FU_MEM = 1'b1;

    typedef struct packed {
        logic                 valid;
        logic                 fu;
        logic [TAG_W-1:0]     src1;
        logic                 src1_rdy;
        logic [TAG_W-1:0]     src2;
        logic                 src2_rdy;
        logic [TAG_W-1:0]     dst;
        logic [ROB_W-1:0]     rob;
        logic [PAYLOAD_W-1:0] payload;
    } rs_entry_t;

endpackage

// File: rtl/rs_age_select.sv
// rtl/rs_age_select.sv - oldest-candidate picker driven by an age matrix
//
// Purpose: one-hot grant of the candidate that is older than every other candidate.
// Ports:
//   cand_i  - candidate entries
//   age_i   - age_i[i][j] = 1 means entry j is older than entry i
//   grant_o - one-hot grant (all zero when no candidate)
module rs_age_select #(
    parameter int DEPTH = 8
) (
    input  logic [DEPTH-1:0]            cand_i,
    input  logic [DEPTH-1:0][DEPTH-1:0] age_i,
    output logic [DEPTH-1:0]            grant_o
);

    always_comb begin
        grant_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            // entry i wins when no other candidate is recorded as older than it
            grant_o[i] = cand_i[i] & ~|(age_i[i] & cand_i);
        end
    end

endmodule

// File: rtl/rs_issue_scheduler.sv
// rtl/rs_issue_scheduler.sv - unified reservation station with ALU/LSU issue select
//
// Purpose: buffers renamed ops, wakes sources from CDB broadcasts, and issues the
// oldest ready ALU op and oldest ready MEM op each cycle.
// Ports:
//   clk, rstn, flush            - clock, async active-low reset, sync flush
//   disp_*                      - dispatch request/handshake and op fields
//   cdb_valid, cdb_tag          - wakeup broadcasts, port k at [k*TAG_W +: TAG_W]
//   alu_*, lsu_*                - issue ports (valid/ready handshake + op fields)
//   occupancy                   - number of valid entries
module rs_issue_scheduler
    import rs_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int NUM_CDB = 2
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       flush,
    input  logic                       disp_valid,
    output logic                       disp_ready,
    input  logic                       disp_fu,
    input  logic [TAG_W-1:0]           disp_src1,
    input  logic [TAG_W-1:0]           disp_src2,
    input  logic                       disp_src1_rdy,
    input  logic                       disp_src2_rdy,
    input  logic [TAG_W-1:0]           disp_dst,
    input  logic [ROB_W-1:0]           disp_rob,
    input  logic [PAYLOAD_W-1:0]       disp_payload,
    input  logic [NUM_CDB-1:0]         cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0]   cdb_tag,
    output logic                       alu_valid,
    input  logic                       alu_ready,
    output logic [TAG_W-1:0]           alu_src1,
    output logic [TAG_W-1:0]           alu_src2,
    output logic [TAG_W-1:0]           alu_dst,
    output logic [ROB_W-1:0]           alu_rob,
    output logic [PAYLOAD_W-1:0]       alu_payload,
    output logic                       lsu_valid,
    input  logic                       lsu_ready,
    output logic [TAG_W-1:0]           lsu_src1,
    output logic [TAG_W-1:0]           lsu_src2,
    output logic [TAG_W-1:0]           lsu_dst,
    output logic [ROB_W-1:0]           lsu_rob,
    output logic [PAYLOAD_W-1:0]       lsu_payload,
    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    rs_entry_t [DEPTH-1:0]            ent_q, ent_d;
    logic [DEPTH-1:0][DEPTH-1:0]      age_q, age_d;
    logic [CNT_W-1:0]                 occ_q, occ_d;

    logic [DEPTH-1:0] valid_vec, cand_alu, cand_mem, gnt_alu, gnt_mem, freed;
    logic [IDX_W-1:0] free_idx;
    logic             disp_fire, alu_fire, lsu_fire;
    rs_entry_t        alu_sel, lsu_sel, new_ent;

    function automatic logic cdb_hit(input logic [TAG_W-1:0]         tag,
                                     input logic [NUM_CDB-1:0]       vld,
                                     input logic [NUM_CDB*TAG_W-1:0] tags);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < NUM_CDB; k++) begin
            if (vld[k] && tags[k*TAG_W +: TAG_W] == tag) hit = 1'b1;
        end
        return hit;
    endfunction

    always_comb begin
        valid_vec = '0;
        cand_alu  = '0;
        cand_mem  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid_vec[i] = ent_q[i].valid;
            cand_alu[i]  = ent_q[i].valid & ent_q[i].src1_rdy & ent_q[i].src2_rdy
                           & (ent_q[i].fu == FU_ALU);
            cand_mem[i]  = ent_q[i].valid & ent_q[i].src1_rdy & ent_q[i].src2_rdy
                           & (ent_q[i].fu == FU_MEM);
        end
    end

    rs_age_select #(.DEPTH(DEPTH)) u_sel_alu (
        .cand_i  (cand_alu),
        .age_i   (age_q),
        .grant_o (gnt_alu)
    );

    rs_age_select #(.DEPTH(DEPTH)) u_sel_mem (
        .cand_i  (cand_mem),
        .age_i   (age_q),
        .grant_o (gnt_mem)
    );

    assign alu_valid  = (|cand_alu) & ~flush;
    assign lsu_valid  = (|cand_mem) & ~flush;
    assign alu_fire   = alu_valid & alu_ready;
    assign lsu_fire   = lsu_valid & lsu_ready;
    assign disp_ready = ~&valid_vec;
    assign disp_fire  = disp_valid & disp_ready & ~flush;
    assign freed      = (alu_fire ? gnt_alu : '0) | (lsu_fire ? gnt_mem : '0);
    assign occupancy  = occ_q;

    // lowest-index free slot: scan downward so the last assignment wins
    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_vec[i]) free_idx = IDX_W'(i);
        end
    end

    always_comb begin
        new_ent          = '0;
        new_ent.valid    = 1'b1;
        new_ent.fu       = disp_fu;
        new_ent.src1     = disp_src1;
        new_ent.src2     = disp_src2;
        new_ent.src1_rdy = disp_src1_rdy | (disp_src1 == '0) | cdb_hit(disp_src1, cdb_valid, cdb_tag);
        new_ent.src2_rdy = disp_src2_rdy | (disp_src2 == '0) | cdb_hit(disp_src2, cdb_valid, cdb_tag);
        new_ent.dst      = disp_dst;
        new_ent.rob      = disp_rob;
        new_ent.payload  = disp_payload;
    end

    // data outputs are zero whenever the port is not valid (including during flush)
    always_comb begin
        alu_sel = '0;
        lsu_sel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (alu_valid && gnt_alu[i]) alu_sel = alu_sel | ent_q[i];
            if (lsu_valid && gnt_mem[i]) lsu_sel = lsu_sel | ent_q[i];
        end
    end

    assign alu_src1    = alu_sel.src1;
    assign alu_src2    = alu_sel.src2;
    assign alu_dst     = alu_sel.dst;
    assign alu_rob     = alu_sel.rob;
    assign alu_payload = alu_sel.payload;
    assign lsu_src1    = lsu_sel.src1;
    assign lsu_src2    = lsu_sel.src2;
    assign lsu_dst     = lsu_sel.dst;
    assign lsu_rob     = lsu_sel.rob;
    assign lsu_payload = lsu_sel.payload;

    always_comb begin
        ent_d = ent_q;
        age_d = age_q;
        occ_d = occ_q + CNT_W'(disp_fire) - CNT_W'(alu_fire) - CNT_W'(lsu_fire);
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_q[i].valid && cdb_hit(ent_q[i].src1, cdb_valid, cdb_tag)) ent_d[i].src1_rdy = 1'b1;
            if (ent_q[i].valid && cdb_hit(ent_q[i].src2, cdb_valid, cdb_tag)) ent_d[i].src2_rdy = 1'b1;
            if (freed[i]) ent_d[i].valid = 1'b0;
            age_d[i] = age_q[i] & ~freed;
        end
        if (disp_fire) begin
            ent_d[free_idx] = new_ent;
            // new op is younger than everything that survives this edge
            age_d[free_idx] = valid_vec & ~freed;
        end
        if (flush) begin
            ent_d = '0;
            age_d = '0;
            occ_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ent_q <= '0;
            age_q <= '0;
            occ_q <= '0;
        end else begin
            ent_q <= ent_d;
            age_q <= age_d;
            occ_q <= occ_d;
        end
    end

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// tb/tb_rs_issue_scheduler.sv - directed self-checking bench for rs_issue_scheduler
module tb_rs_issue_scheduler;
    import rs_pkg::*;

    logic                  clk = 1'b0;
    logic                  rstn;
    logic                  flush;
    logic                  disp_valid;
    logic                  disp_ready;
    logic                  disp_fu;
    logic [TAG_W-1:0]      disp_src1, disp_src2, disp_dst;
    logic                  disp_src1_rdy, disp_src2_rdy;
    logic [ROB_W-1:0]      disp_rob;
    logic [PAYLOAD_W-1:0]  disp_payload;
    logic [1:0]            cdb_valid;
    logic [2*TAG_W-1:0]    cdb_tag;
    logic                  alu_valid, alu_ready, lsu_valid, lsu_ready;
    logic [TAG_W-1:0]      alu_src1, alu_src2, alu_dst, lsu_src1, lsu_src2, lsu_dst;
    logic [ROB_W-1:0]      alu_rob, lsu_rob;
    logic [PAYLOAD_W-1:0]  alu_payload, lsu_payload;
    logic [3:0]            occupancy;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    rs_issue_scheduler #(.DEPTH(8), .NUM_CDB(2)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .flush         (flush),
        .disp_valid    (disp_valid),
        .disp_ready    (disp_ready),
        .disp_fu       (disp_fu),
        .disp_src1     (disp_src1),
        .disp_src2     (disp_src2),
        .disp_src1_rdy (disp_src1_rdy),
        .disp_src2_rdy (disp_src2_rdy),
        .disp_dst      (disp_dst),
        .disp_rob      (disp_rob),
        .disp_payload  (disp_payload),
        .cdb_valid     (cdb_valid),
        .cdb_tag       (cdb_tag),
        .alu_valid     (alu_valid),
        .alu_ready     (alu_ready),
        .alu_src1      (alu_src1),
        .alu_src2      (alu_src2),
        .alu_dst       (alu_dst),
        .alu_rob       (alu_rob),
        .alu_payload   (alu_payload),
        .lsu_valid     (lsu_valid),
        .lsu_ready     (lsu_ready),
        .lsu_src1      (lsu_src1),
        .lsu_src2      (lsu_src2),
        .lsu_dst       (lsu_dst),
        .lsu_rob       (lsu_rob),
        .lsu_payload   (lsu_payload),
        .occupancy     (occupancy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // advance one clock edge; inputs are then safe to change and outputs to sample
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic dispatch(input logic fu, input logic [TAG_W-1:0] s1, input logic r1,
                            input logic [TAG_W-1:0] s2, input logic r2,
                            input logic [TAG_W-1:0] dst, input logic [ROB_W-1:0] rob);
        disp_valid    = 1'b1;
        disp_fu       = fu;
        disp_src1     = s1;
        disp_src1_rdy = r1;
        disp_src2     = s2;
        disp_src2_rdy = r2;
        disp_dst      = dst;
        disp_rob      = rob;
        disp_payload  = {27'd0, rob};
        step();
        disp_valid    = 1'b0;
        #1;
    endtask

    task automatic cdb(input logic [TAG_W-1:0] tag);
        cdb_valid = 2'b01;
        cdb_tag   = {{TAG_W{1'b0}}, tag};
    endtask

    initial begin
        rstn = 1'b0; flush = 1'b0; disp_valid = 1'b0; disp_fu = 1'b0;
        disp_src1 = '0; disp_src2 = '0; disp_dst = '0; disp_rob = '0; disp_payload = '0;
        disp_src1_rdy = 1'b0; disp_src2_rdy = 1'b0;
        cdb_valid = '0; cdb_tag = '0; alu_ready = 1'b0; lsu_ready = 1'b0;
        #12;
        check("rst_occ",        occupancy, 0);
        check("rst_alu_valid",  alu_valid, 0);
        check("rst_lsu_valid",  lsu_valid, 0);
        check("rst_disp_ready", disp_ready, 1);
        check("rst_alu_dst",    alu_dst, 0);
        rstn = 1'b1;
        step();

        // 1: single ready ALU op
        dispatch(FU_ALU, 6'd3, 1'b1, 6'd0, 1'b0, 6'd9, 5'd1);
        check("t1_valid", alu_valid, 1);
        check("t1_dst",   alu_dst, 9);
        check("t1_rob",   alu_rob, 1);
        check("t1_src1",  alu_src1, 3);
        check("t1_occ",   occupancy, 1);
        alu_ready = 1'b1;
        step();
        alu_ready = 1'b0;
        check("t1_occ_after", occupancy, 0);
        check("t1_valid_after", alu_valid, 0);

        // 2: younger ready op bypasses older waiting op; wakeup is not same-cycle
        dispatch(FU_ALU, 6'd5, 1'b0, 6'd0, 1'b0, 6'd10, 5'd2);
        dispatch(FU_ALU, 6'd0, 1'b0, 6'd0, 1'b0, 6'd11, 5'd3);
        check("t2_b_first", alu_rob, 3);
        alu_ready = 1'b1;
        step();
        cdb(6'd5);
        #1;
        check("t2_no_bypass", alu_valid, 0);
        step();
        cdb_valid = '0;
        #1;
        check("t2_a_valid", alu_valid, 1);
        check("t2_a_rob",   alu_rob, 2);
        step();
        alu_ready = 1'b0;
        check("t2_occ", occupancy, 0);

        // 3: stall holds the oldest op, then A issues before B
        dispatch(FU_ALU, 6'd0, 1'b0, 6'd0, 1'b0, 6'd12, 5'd4);
        dispatch(FU_ALU, 6'd0, 1'b0, 6'd0, 1'b0, 6'd13, 5'd5);
        for (int c = 0; c < 3; c++) begin
            check("t3_hold", alu_rob, 4);
            step();
        end
        alu_ready = 1'b1;
        #1;
        check("t3_a", alu_rob, 4);
        step();
        check("t3_b", alu_rob, 5);
        step();
        alu_ready = 1'b0;
        check("t3_occ", occupancy, 0);

        // 4: fill to capacity, overflow dispatch ignored
        for (int i = 0; i < 8; i++)
            dispatch(FU_ALU, TAG_W'(20 + i), 1'b0, 6'd0, 1'b1, 6'd30, ROB_W'(i));
        check("t4_full_ready", disp_ready, 0);
        check("t4_occ8",       occupancy, 8);
        dispatch(FU_ALU, 6'd0, 1'b1, 6'd0, 1'b1, 6'd31, 5'd31);
        check("t4_ignored",    occupancy, 8);
        check("t4_none_ready", alu_valid, 0);
        cdb(6'd20);
        step();
        cdb_valid = '0;
        #1;
        check("t4_wake_rob", alu_rob, 0);
        alu_ready = 1'b1;
        step();
        alu_ready = 1'b0;
        check("t4_disp_ready", disp_ready, 1);
        check("t4_occ7",       occupancy, 7);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("t4_flush_occ", occupancy, 0);

        // 5: dual issue
        dispatch(FU_ALU, 6'd0, 1'b0, 6'd0, 1'b0, 6'd14, 5'd6);
        dispatch(FU_MEM, 6'd2, 1'b1, 6'd0, 1'b0, 6'd15, 5'd7);
        check("t5_occ2",      occupancy, 2);
        check("t5_lsu_valid", lsu_valid, 1);
        check("t5_lsu_rob",   lsu_rob, 7);
        check("t5_lsu_dst",   lsu_dst, 15);
        check("t5_alu_rob",   alu_rob, 6);
        alu_ready = 1'b1;
        lsu_ready = 1'b1;
        step();
        alu_ready = 1'b0;
        lsu_ready = 1'b0;
        check("t5_occ0", occupancy, 0);

        // 6: flush drops issue and dispatch; async reset clears immediately
        for (int i = 0; i < 5; i++)
            dispatch(FU_ALU, 6'd0, 1'b1, 6'd0, 1'b1, 6'd16, ROB_W'(10 + i));
        check("t6_occ5", occupancy, 5);
        flush = 1'b1;
        alu_ready = 1'b1;
        disp_valid = 1'b1;
        #1;
        check("t6_flush_valid", alu_valid, 0);
        check("t6_flush_rob",   alu_rob, 0);
        step();
        flush = 1'b0;
        disp_valid = 1'b0;
        alu_ready = 1'b0;
        #1;
        check("t6_occ_after", occupancy, 0);
        check("t6_valid_after", alu_valid, 0);
        dispatch(FU_ALU, 6'd0, 1'b1, 6'd0, 1'b1, 6'd17, 5'd20);
        dispatch(FU_MEM, 6'd0, 1'b1, 6'd0, 1'b1, 6'd18, 5'd21);
        check("t6_occ2", occupancy, 2);
        #2;
        rstn = 1'b0;
        #1;
        check("t6_rst_occ",   occupancy, 0);
        check("t6_rst_alu",   alu_valid, 0);
        check("t6_rst_lsu",   lsu_valid, 0);
        check("t6_rst_ready", disp_ready, 1);
        check("t6_rst_rob",   lsu_rob, 0);
        rstn = 1'b1;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rs_issue_scheduler.md
Name: rs_issue_scheduler

Overview:
- Unified reservation station and issue scheduler for the out-of-order core. Sits between rename/dispatch and the execution units.
- Buffers renamed micro-ops and wakes up their source operands from common-data-bus (CDB) tag broadcasts.
- Each cycle, selects the oldest ready ALU op and the oldest ready MEM op and issues them to the ALU and LSU ports under valid/ready handshakes.

Parameters:
- DEPTH, 8: number of RS entries (power of 2, ≥2).
- TAG_W, 6: physical-register tag width. Tag 0 is hard-wired ready.
- ROB_W, 5: ROB index width.
- PAYLOAD_W, 32: opaque op payload (opcode, imm, funct), carried unmodified.
- NUM_CDB, 2: number of CDB broadcast ports.

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset; asynchronous, active-low.
- flush  in  1  synchronous pipeline flush (mispredict).
- disp_valid  in  1  dispatch request.
- disp_ready  out  1  high when at least one free entry exists.
- disp_fu  in  1  0=ALU, 1=MEM.
- disp_src1, disp_src2  in  TAG_W each  source tags.
- disp_src1_rdy, disp_src2_rdy  in  1 each  source ready per rename table.
- disp_dst  in  TAG_W  destination tag.
- disp_rob  in  ROB_W  ROB index.
- disp_payload  in  PAYLOAD_W  opaque op.
- cdb_valid  in  NUM_CDB  broadcast valids.
- cdb_tag  in  NUM_CDB*TAG_W  broadcast tags, port k at bits [k*TAG_W +: TAG_W].
- alu_valid  out  1  ALU issue valid.
- alu_ready  in  1  ALU accepts.
- alu_src1, alu_src2, alu_dst  out  TAG_W each  ALU op tags.
- alu_rob  out  ROB_W  ALU op ROB index.
- alu_payload  out  PAYLOAD_W  ALU op payload.
- lsu_valid, lsu_ready, lsu_src1, lsu_src2, lsu_dst, lsu_rob, lsu_payload: same widths and roles as the ALU set, for the LSU port.
- occupancy  out  $clog2(DEPTH)+1  number of valid entries.

Behaviour:
- Reset (rstn low, asynchronous): all entries invalid; age matrix cleared. Outputs: occupancy=0, alu_valid=0, lsu_valid=0, disp_ready=1, all data outputs 0.
- Entry state: valid, fu, src1/src2 tag + ready bit, dst, rob, payload.
- Dispatch: on disp_valid&disp_ready at a clock edge, write to the lowest-index free entry.
  - Source ready bit = disp_srcN_rdy OR (srcN==0) OR (a CDB port in the same cycle broadcasts srcN with its valid high).
  - disp_valid while full: ignored; no state change.
- Wakeup: on each edge, every valid entry whose srcN tag matches a valid CDB tag sets that ready bit.
  - Takes effect the next cycle; there is no same-cycle wakeup-to-issue bypass.
- Age: DEPTH×DEPTH age matrix.
  - On dispatch into entry i, row i is set to the current valid vector: i is younger than every entry present.
  - Column i is cleared when entry i frees.
- Select: combinational from registered state.
  - Candidates = valid & both sources ready & matching fu.
  - Grant = the candidate older than all other candidates.
  - alu_valid/lsu_valid = a candidate exists AND NOT flush. Data outputs reflect the granted entry and are 0 when the port is not valid.
- Issue: entry frees on the edge where its port's valid&ready are both high.
  - When ready is low, valid and data hold stable unless an older op becomes ready; regrant to the older op is permitted.
  - Both ports may issue in the same cycle.
- Issue-to-dispatch latency: an op dispatched at edge t with both sources ready can issue in the cycle after t (earliest handshake at edge t+1).
- Simultaneous events:
  - Dispatch into a slot freed by issue on the same edge is not allowed; disp_ready reflects pre-edge state.
  - Dispatch and wakeup on the same edge are both honoured.
- Flush: at the edge with flush high, all entries are invalidated and the age matrix is cleared. Dispatch and issue in that cycle are discarded; occupancy becomes 0 next cycle.
- occupancy update: occupancy += dispatch − number of issues. It never exceeds DEPTH.

Decomposition:
- Shared package rs_pkg holds: FU_ALU/FU_MEM constants, TAG_W/ROB_W defaults, and the rs_entry_t struct (valid, fu, src tags/ready, dst, rob, payload).
- One sub-module, rs_age_select: takes the candidate vector and age matrix, returns a one-hot oldest grant. It is instantiated twice, once for ALU and once for MEM.

Test Plan:
1. Reset, then dispatch ALU op src1=3 rdy, src2=0, dst=9, rob=1 at cycle 2 -> alu_valid=1 in cycle 3 with alu_dst=9, alu_rob=1. With alu_ready=1 the entry frees and occupancy returns 0.
2. Dispatch ALU ops A (src1=5 not ready) then B (ready) -> B issues first. Broadcast cdb_tag=5 -> A issues the following cycle, not the cycle of the broadcast.
3. Dispatch A then B, both ready, with alu_ready=0 for 3 cycles -> alu_rob holds A's rob for all 3 cycles. Raise alu_ready -> A issues, then B.
4. Dispatch 8 ops with unready sources -> disp_ready=0 and occupancy=8. A 9th disp_valid is ignored. One wakeup+issue -> disp_ready=1.
5. One ready ALU op and one ready MEM op, both ports ready -> both issue in the same cycle; occupancy drops by 2.
6. Fill 5 entries, assert flush with alu_ready=1 -> alu_valid=0 that cycle, occupancy=0 next cycle. Dispatch in the flush cycle is dropped. Async rstn pulse mid-operation -> outputs go to reset values immediately.
